// File: rtl/pipe_stage_chain_pkg.sv
// rtl/pipe_stage_chain_pkg.sv - shared constants and helpers for the stage chain
package pipe_stage_chain_pkg;
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_DEPTH   = 4;
    localparam int MAX_WIDTH   = 64;
    localparam int MAX_DEPTH   = 8;
    localparam int STALL_CNT_W = 16;
    localparam int OCC_W       = 4;

    // Counter sticks at all-ones instead of wrapping back to zero.
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    endfunction
endpackage

// File: rtl/pipe_stage_chain_reg.sv
// rtl/pipe_stage_chain_reg.sv - one payload register plus live bit (module pipe_stage_reg)
module pipe_stage_reg
    import pipe_stage_chain_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             live_o,
    output logic [WIDTH-1:0] data_o
);
    logic             live_q, live_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Payload only moves on load, so an emptied stage keeps its old bits.
    always_comb begin
        live_d = live_q;
        data_d = data_q;
        if (load_i) begin
            live_d = 1'b1;
            data_d = data_i;
        end else if (clear_i) begin
            live_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            live_q <= 1'b0;
            data_q <= '0;
        end else begin
            live_q <= live_d;
            data_q <= data_d;
        end
    end

    assign live_o = live_q;
    assign data_o = data_q;
endmodule

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - bubble-collapsing register chain with per-stage hold and flush
module pipe_stage_chain
    import pipe_stage_chain_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    input  logic [DEPTH-1:0]       hold,
    input  logic [DEPTH-1:0]       flush,
    output logic [DEPTH-1:0]       stage_valid,
    output logic [DEPTH*WIDTH-1:0] stage_data,
    output logic [OCC_W-1:0]       occupancy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    if (WIDTH < 1 || WIDTH > MAX_WIDTH || DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_param
        $fatal(1, "pipe_stage_chain: WIDTH or DEPTH out of range");
    end

    logic [DEPTH-1:0]       live;
    logic [DEPTH-1:0]       adv;
    logic [DEPTH-1:0]       acc;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [OCC_W-1:0]       occ;

    // Readiness ripples from the output side back toward stage 0 in one cycle.
    always_comb begin
        logic room;
        adv  = '0;
        acc  = '0;
        room = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            adv[k] = live[k] & ~hold[k] & ~flush[k] & room;
            acc[k] = ~live[k] | adv[k] | flush[k];
            room   = acc[k];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             src_valid;
        logic [WIDTH-1:0] src_data;
        if (k == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_data  = in_data;
        end else begin : g_body
            assign src_valid = adv[k-1];
            assign src_data  = stage_data[(k-1)*WIDTH +: WIDTH];
        end

        pipe_stage_reg #(.WIDTH(WIDTH)) u_reg (
            .clock   (clock),
            .resetn  (resetn),
            .load_i  (acc[k] & src_valid),
            .clear_i (acc[k] & ~src_valid),
            .data_i  (src_data),
            .live_o  (live[k]),
            .data_o  (stage_data[k*WIDTH +: WIDTH])
        );
    end

    always_comb begin
        occ = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ = occ + OCC_W'(live[k]);
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && !acc[0]) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign in_ready    = acc[0];
    assign out_valid   = live[DEPTH-1] & ~flush[DEPTH-1];
    assign out_data    = stage_data[(DEPTH-1)*WIDTH +: WIDTH];
    assign stage_valid = live;
    assign occupancy   = occ;
    assign stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - randomized and directed checks of pipe_stage_chain
module tb_pipe_stage_chain;
    localparam int W = 32;
    localparam int D = 4;

    logic           clock = 1'b0;
    logic           resetn;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [D-1:0]   hold;
    logic [D-1:0]   flush;
    logic [D-1:0]   stage_valid;
    logic [D*W-1:0] stage_data;
    logic [3:0]     occupancy;
    logic [15:0]    stall_cnt;

    always #5 clock = ~clock;

    pipe_stage_chain #(.WIDTH(W), .DEPTH(D)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .hold        (hold),
        .flush       (flush),
        .stage_valid (stage_valid),
        .stage_data  (stage_data),
        .occupancy   (occupancy),
        .stall_cnt   (stall_cnt)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference: each slot holds its payload, or -1 when the stage is empty.
    longint     m_slot[D];
    int         m_stall;
    bit         m_leave[D];
    bit         m_room[D];
    bit         m_in_ready;
    bit         m_out_valid;
    logic [W-1:0] got[$];
    logic       last_in_ready;

    task automatic model_reset();
        for (int k = 0; k < D; k++) m_slot[k] = -1;
        m_stall = 0;
    endtask

    task automatic model_comb(input logic ordy, input logic [D-1:0] hld, input logic [D-1:0] fl);
        bit down_room;
        bit full;
        down_room = ordy;
        for (int k = D - 1; k >= 0; k--) begin
            full       = (m_slot[k] >= 0);
            m_leave[k] = full && down_room && !hld[k] && !fl[k];
            m_room[k]  = !full || m_leave[k] || fl[k];
            down_room  = m_room[k];
        end
        m_in_ready  = m_room[0];
        m_out_valid = (m_slot[D-1] >= 0) && !fl[D-1];
    endtask

    task automatic model_clock(input logic iv, input logic [W-1:0] id);
        longint nxt[D];
        for (int k = 0; k < D; k++) begin
            if (!m_room[k])    nxt[k] = m_slot[k];
            else if (k == 0)   nxt[k] = iv ? longint'(id) : -1;
            else               nxt[k] = m_leave[k-1] ? m_slot[k-1] : -1;
        end
        if (iv && !m_in_ready && m_stall < 65535) m_stall++;
        for (int k = 0; k < D; k++) m_slot[k] = nxt[k];
    endtask

    // Called one time unit after a rising edge; returns at the same phase.
    task automatic do_cycle(input logic iv, input logic [W-1:0] id, input logic ordy,
                            input logic [D-1:0] hld, input logic [D-1:0] fl);
        int occ;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        hold      = hld;
        flush     = fl;
        model_comb(ordy, hld, fl);
        #1;
        last_in_ready = in_ready;
        check_eq("in_ready", in_ready, m_in_ready);
        check_eq("out_valid", out_valid, m_out_valid);
        if (m_out_valid) check_eq("out_data", out_data, m_slot[D-1]);
        if (out_valid && ordy) got.push_back(out_data);
        @(posedge clock);
        #1;
        model_clock(iv, id);
        occ = 0;
        for (int k = 0; k < D; k++) begin
            if (m_slot[k] >= 0) begin
                occ++;
                check_eq($sformatf("stage_data[%0d]", k), stage_data[k*W +: W], m_slot[k]);
            end
            check_eq($sformatf("stage_valid[%0d]", k), stage_valid[k], m_slot[k] >= 0);
        end
        check_eq("occupancy", occupancy, occ);
        check_eq("stall_cnt", stall_cnt, m_stall);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        hold      = '0;
        flush     = '0;
        #2 resetn = 1'b0;
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_occupancy", occupancy, 0);
        check_eq("rst_stall_cnt", stall_cnt, 0);
        check_eq("rst_stage_valid", stage_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_in_ready", in_ready, 1);
        @(posedge clock);
        #1 resetn = 1'b1;
        model_reset();
        got.delete();
    endtask

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        hold      = '0;
        flush     = '0;
        model_reset();
        @(posedge clock);
        #1 resetn = 1'b1;
        do_reset();

        // Back-to-back pushes through an empty chain
        do_cycle(1, 32'h11, 1, 0, 0); check_eq("r35_rdy_a", last_in_ready, 1);
        do_cycle(1, 32'h22, 1, 0, 0); check_eq("r35_rdy_b", last_in_ready, 1);
        do_cycle(1, 32'h33, 1, 0, 0); check_eq("r35_rdy_c", last_in_ready, 1);
        do_cycle(0, 0, 1, 0, 0);
        check_eq("r35_v1", out_valid, 1); check_eq("r35_d1", out_data, 32'h11);
        do_cycle(0, 0, 1, 0, 0);
        check_eq("r35_v2", out_valid, 1); check_eq("r35_d2", out_data, 32'h22);
        do_cycle(0, 0, 1, 0, 0);
        check_eq("r35_v3", out_valid, 1); check_eq("r35_d3", out_data, 32'h33);
        do_cycle(0, 0, 1, 0, 0);
        check_eq("r35_empty", out_valid, 0);

        // Fill, stall, then drain in order
        do_reset();
        for (int i = 0; i < 4; i++) do_cycle(1, 32'hA0 + i, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            do_cycle(1, 32'hB0 + i, 0, 0, 0);
            check_eq("r36_in_ready", last_in_ready, 0);
        end
        check_eq("r36_occ", occupancy, 4);
        check_eq("r36_stall", stall_cnt, 5);
        for (int i = 0; i < 4; i++) do_cycle(0, 0, 1, 0, 0);
        check_eq("r36_cnt", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) check_eq("r36_order", got[i], 32'hA0 + i);

        // Single-cycle hold in the middle of the chain
        do_reset();
        do_cycle(1, 1, 1, 0, 0);
        do_cycle(1, 2, 1, 0, 0);
        do_cycle(1, 3, 1, 0, 0);
        do_cycle(0, 0, 1, 4'b0010, 0);
        check_eq("r37_valid", stage_valid, 4'b1011);
        check_eq("r37_s3", stage_data[3*W +: W], 1);
        check_eq("r37_s1", stage_data[1*W +: W], 2);
        check_eq("r37_s0", stage_data[0*W +: W], 3);
        for (int i = 0; i < 6; i++) do_cycle(0, 0, 1, 0, 0);
        check_eq("r37_cnt", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) check_eq("r37_order", got[i], i + 1);

        // Flush overrides hold on the input-side stages
        do_reset();
        for (int i = 0; i < 4; i++) do_cycle(1, 32'hC0 + i, 0, 0, 0);
        do_cycle(0, 0, 0, 4'b0001, 4'b0011);
        check_eq("r38_occ", occupancy, 2);
        check_eq("r38_valid", stage_valid, 4'b1100);
        for (int i = 0; i < 6; i++) do_cycle(0, 0, 1, 0, 0);
        check_eq("r38_cnt", got.size(), 2);
        for (int i = 0; i < 2 && i < got.size(); i++) check_eq("r38_order", got[i], 32'hC0 + i);

        // Asynchronous reset with three entries in flight and a nonzero stall count
        do_reset();
        for (int i = 0; i < 4; i++) do_cycle(1, 32'hD0 + i, 0, 0, 0);
        do_cycle(1, 32'hDD, 0, 0, 0);
        do_cycle(1, 32'hDE, 0, 0, 0);
        do_cycle(0, 0, 1, 0, 0);
        check_eq("r39_occ", occupancy, 3);
        check_eq("r39_stall", stall_cnt, 2);
        do_reset();

        // Randomized traffic with occasional hold and flush
        for (int i = 0; i < 3000; i++) begin
            logic [D-1:0] h;
            logic [D-1:0] f;
            for (int k = 0; k < D; k++) begin
                h[k] = ($urandom_range(0, 7) == 0);
                f[k] = ($urandom_range(0, 15) == 0);
            end
            do_cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0, h, f);
        end

        // Stall counter saturation
        do_reset();
        in_valid  = 1'b1;
        in_data   = 32'h5A;
        out_ready = 1'b0;
        repeat (70000) @(posedge clock);
        #1;
        check_eq("r40_sat", stall_cnt, 16'hFFFF);
        repeat (5) @(posedge clock);
        #1;
        check_eq("r40_nowrap", stall_cnt, 16'hFFFF);
        check_eq("r40_occ", occupancy, 4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 Parameter WIDTH, default 32: payload bits per stage, legal range 1..64.
REQ-002 Parameter DEPTH, default 4: number of register stages, legal range 1..8; stage 0 is the input side, stage DEPTH-1 the output side.
REQ-003 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port resetn, input, 1: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1: producer offers in_data this cycle.
REQ-006 Port in_ready, output, 1: stage 0 accepts this cycle.
REQ-007 Port in_data, input, WIDTH: incoming payload.
REQ-008 Port out_valid, output, 1: stage DEPTH-1 holds a live entry.
REQ-009 Port out_ready, input, 1: consumer takes out_data this cycle.
REQ-010 Port out_data, output, WIDTH: payload of stage DEPTH-1.
REQ-011 Port hold, input, DEPTH: hold[k] keeps stage k from advancing (load-use style stall).
REQ-012 Port flush, input, DEPTH: flush[k] kills the entry currently in stage k (branch/jump squash).
REQ-013 Port stage_valid, output, DEPTH: live bit of every stage, for hazard logic.
REQ-014 Port stage_data, output, DEPTH*WIDTH: payload of stage k at bits [k*WIDTH +: WIDTH].
REQ-015 Port occupancy, output, 4: count of live stages, 0..DEPTH.
REQ-016 Port stall_cnt, output, 16: cycles with in_valid=1 and in_ready=0.

Function
REQ-017 Entry move: adv[DEPTH-1] = live[DEPTH-1] & out_ready & !hold[DEPTH-1] & !flush[DEPTH-1]; for k<DEPTH-1, adv[k] = live[k] & !hold[k] & !flush[k] & acc[k+1].
REQ-018 Acceptance: acc[k] = !live[k] | adv[k] | flush[k]; in_ready = acc[0]; acc/adv are combinational, no extra latency.
REQ-019 Stage k load: when acc[k] and the upstream source is valid and moving (stage k-1 adv, or in_valid for k=0), stage k captures that payload and sets live; if acc[k] and nothing arrives, live clears.
REQ-020 Stage k with !acc[k] keeps payload and live bit unchanged (bubble-collapsing: a stalled stage fills only empty stages behind it).
REQ-021 Latency into empty chain, no hold/flush, out_ready=1: entry accepted at edge N appears on out_data/out_valid after edge N+DEPTH-1; throughput one entry per cycle.
REQ-022 Flush precedence: flush[k] overrides hold[k]; the killed entry is never passed to stage k+1 or to the output; stage k still accepts from upstream in the same cycle.
REQ-023 out_valid = live[DEPTH-1] & !flush[DEPTH-1]; out_data is always the stage DEPTH-1 register, unmasked.
REQ-024 Simultaneous hold[k] and out_ready with downstream space: stage k stays; stages above k advance; stage k+1 becomes empty if nothing else feeds it.
REQ-025 Full chain, out_ready=1, in_valid=1: all stages advance and in_ready=1 in the same cycle (no dead cycle).
REQ-026 occupancy reflects registered live bits (post-edge value), never exceeds DEPTH.
REQ-027 stall_cnt increments by 1 per cycle with in_valid & !in_ready, saturates at 0xFFFF, never wraps.
REQ-028 Payload registers of non-loading stages do not change; payloads of empty stages are don't-care but stable.

Reset
REQ-029 resetn=0 asynchronously clears all live bits, all payload registers to 0, stall_cnt to 0; thus out_valid=0, occupancy=0, stage_valid=0, out_data=0.
REQ-030 Reset asserted mid-transfer discards all in-flight entries; in_ready is combinationally 1 while reset is held low.
REQ-031 First capture occurs at the first rising edge after resetn deasserts.

Structure
REQ-032 Shared package holds default WIDTH/DEPTH constants, MAX_DEPTH=8, and the 16-bit stall counter width constant.
REQ-033 One sub-module, pipe_stage_reg: one WIDTH-bit payload register plus live bit with load/clear controls; the chain instantiates it DEPTH times via generate.
REQ-034 Illegal WIDTH or DEPTH shall stop elaboration.

Verification
REQ-035 DEPTH=4, out_ready=1, push 0x11,0x22,0x33 back-to-back -> 0x11 out after 3 edges from its capture edge, then 0x22, 0x33 on consecutive cycles; in_ready stays 1.
REQ-036 Fill 4 entries with out_ready=0, then in_valid=1 for 5 cycles -> in_ready=0, occupancy=4, stall_cnt=5; raise out_ready -> 0xA0 delivered first in order, no loss.
REQ-037 Entries 1,2,3 in stages 0,1,2; pulse hold[1] one cycle with out_ready=1 -> stage 2 moves on, stage 1 keeps 2, stage 0 keeps 3 (stage 1 stayed full), output order 1,2,3.
REQ-038 Entries in all stages, flush=4'b0011 with hold[0]=1 -> stages 0,1 empty next cycle, occupancy=2, killed payloads never appear on out_data.
REQ-039 Assert resetn=0 between edges with occupancy=3 -> out_valid, occupancy, stall_cnt 0 immediately, before next clock edge.
REQ-040 Hold in_valid=1, out_ready=0 for 70000 cycles -> stall_cnt saturates at 0xFFFF.
